sub_fp: RTL
===========

Name: sub_fp

Overview:
- Pipelined signed fixed-point subtractor: diff = a - b.
- Operands arrive in independent Q formats; the result is requantized and saturated to an output Q format.
- Companion to the team's fixed-point adder; it sits in the same datapath wherever a difference is needed (error terms, accumulator drain).
- Uses a valid/ready handshake on both sides so it can be chained with backpressure.

Parameters:
- INT_A, 4, integer bits of a, sign bit included (two's complement)
- FRAC_A, 5, fraction bits of a
- INT_B, 3, integer bits of b, sign bit included
- FRAC_B, 5, fraction bits of b
- OUT_INT, 3, integer bits of diff, sign bit included
- OUT_FRAC, 10, fraction bits of diff

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts the pair this cycle
- a  in  INT_A+FRAC_A  signed minuend
- b  in  INT_B+FRAC_B  signed subtrahend
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- diff  out  OUT_INT+OUT_FRAC  signed saturated result
- overflow  out  1  true result > max representable; diff saturated to max
- underflow  out  1  true result < min representable; diff saturated to min
- inexact  out  1  nonzero fraction bits were discarded

Behaviour:
- Reset: clock is clk; reset rst is synchronous and active-low. While rst=0, all stage valids clear; out_valid=0, diff=0, overflow=0, underflow=0, inexact=0. in_ready=1 in the first cycle after reset is released.
- Widths: IMAX=max(INT_A,INT_B), FMAX=max(FRAC_A,FRAC_B), W=IMAX+FMAX.
- Stage S1 (align): sign-extend the integer part to IMAX and zero-pad the fraction on the LSB side to FMAX. Register both aligned operands.
- Stage S2 (subtract): compute a_al - b_al at W+1 bits; the guard bit makes the subtraction exact. Register the result.
- Stage S3 (requantize):
  - Fraction, OUT_FRAC >= FMAX: zero-pad.
  - Fraction, OUT_FRAC < FMAX: truncate toward -inf. Set inexact=1 if any dropped bit is nonzero.
  - Integer: compare the W+1-bit value against the OUT_INT range.
    - Above the range: diff = {0, all 1s} (max), overflow=1.
    - Below the range: diff = {1, all 0s} (min), underflow=1.
    - Otherwise take the low OUT_INT integer bits.
  - overflow and underflow are mutually exclusive.
  - Flags are registered with diff and qualified by out_valid.
- Pipeline control: each stage holds a valid bit. A stage loads when it is empty or the stage after it advances. S3 advances when out_ready=1.
- in_ready = !s1_valid | s1_advance.
- A transfer occurs on in_valid & in_ready (input side) and out_valid & out_ready (output side).
- Latency: 3 cycles from input transfer to out_valid when out_ready stays high. Throughput: 1 result per cycle.
- Backpressure: with out_ready=0, at most 3 results are held; in_ready drops only once all stages are full. Nothing is lost or duplicated, and order is preserved.
- While out_valid=1 and out_ready=0, diff and the flags hold stable.
- Simultaneous accept and drain while full is legal and sustains full rate.
- Reset mid-operation discards all in-flight data.

Optional Feature:
- Macro SUB_FP_ROUND_EN.
- Defined: when OUT_FRAC < FMAX, add half an output LSB before truncation (round half up). Rounding carry is checked for saturation: a rounded value above max saturates and sets overflow. inexact keeps its meaning.
- Undefined: truncation toward -inf, as described in Behaviour. Latency is 3 cycles in both builds.

Decomposition:
- Shared package fp_pkg holds:
  - max-width helper functions
  - the flag-bundle struct {overflow, underflow, inexact}
  - the saturation-limit constant generators
  These are shared with the adder.
- One sub-module, fp_requant: purely combinational. Takes a W+1-bit value with FMAX fraction bits and produces diff plus the flags at OUT_INT/OUT_FRAC. It is reusable by the adder.

Test Plan:
- Defaults, a=9'h050 (2.5), b=8'h28 (1.25) -> after 3 cycles diff=13'h0500 (1.25); all flags 0.
- a=9'h0E0 (7.0), b=8'h80 (-4.0) -> diff=13'h0FFF, overflow=1, underflow=0.
- a=9'h100 (-8.0), b=8'h60 (3.0) -> diff=13'h1000, underflow=1, overflow=0.
- OUT_FRAC=3, a=9'h003, b=0:
  - with SUB_FP_ROUND_EN -> diff=6'h01, inexact=1
  - without SUB_FP_ROUND_EN -> diff=6'h00, inexact=1
- Stream 6 pairs, hold out_ready=0 for 5 cycles -> in_ready=0 once 3 are held, diff stable while stalled; all 6 results emerge in order with none dropped.
- Assert rst=0 with 3 results in flight -> next cycle out_valid=0, diff=0; in_ready=1 in the first cycle after rst=1.

Source files
------------

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared fixed-point helpers for the adder/subtractor family:
//                width helpers, flag bundle, saturation-limit generators.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

  // Status flags that travel alongside every requantized result
  typedef struct packed {
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  // Larger of two widths
  function automatic int fp_max(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  // x - y clamped at zero (amount of padding or dropping between formats)
  function automatic int fp_pos_diff(input int x, input int y);
    return (x > y) ? (x - y) : 0;
  endfunction

  // Largest two's-complement value of a given width: {0, all 1s}
  function automatic logic [63:0] fp_sat_max(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  // Smallest two's-complement value of a given width: {1, all 0s}
  function automatic logic [63:0] fp_sat_min(input int width);
    return ~64'd0 << (width - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_requant.sv
`default_nettype none
// ============================================================================
//  Module      : fp_requant
//  Description : Combinational requantizer. Converts a signed value with
//                IN_FRAC fraction bits to OUT_INT.OUT_FRAC with saturation,
//                producing overflow/underflow/inexact flags.
//                Macro SUB_FP_ROUND_EN: round half up instead of truncating
//                toward -inf when fraction bits are dropped.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_requant
  import fp_pkg::*;
#(
  parameter int IN_W     = 10,
  parameter int IN_FRAC  = 5,
  parameter int OUT_INT  = 3,
  parameter int OUT_FRAC = 10
) (
  input  logic signed [IN_W-1:0]             i_val,
  output logic        [OUT_INT+OUT_FRAC-1:0] o_diff,
  output fp_flags_t                          o_flags
);

  localparam int OW  = OUT_INT + OUT_FRAC;
  localparam int PAD = fp_pos_diff(OUT_FRAC, IN_FRAC);
  localparam int DRP = fp_pos_diff(IN_FRAC, OUT_FRAC);
  // One spare bit above the padded input so a rounding carry never wraps
  localparam int QW  = fp_max(IN_W + PAD + 1, OW + 1);

  localparam logic signed [OW-1:0] C_MAX = OW'(fp_sat_max(OW));
  localparam logic signed [OW-1:0] C_MIN = OW'(fp_sat_min(OW));

  logic signed [QW-1:0] w_ext;
  logic signed [QW-1:0] w_q;
  logic                 w_inexact;

  assign w_ext = {{(QW-IN_W){i_val[IN_W-1]}}, i_val};

  if (DRP == 0) begin : g_pad
    // Output has at least as many fraction bits: exact, zero-pad LSBs
    assign w_q       = w_ext <<< PAD;
    assign w_inexact = 1'b0;
  end else begin : g_drop
    logic signed [QW-1:0] w_biased;
`ifdef SUB_FP_ROUND_EN
    localparam logic [QW-1:0] C_HALF = QW'(64'd1 << (DRP - 1));
    assign w_biased = w_ext + C_HALF;
`else
    assign w_biased = w_ext;
`endif
    // Arithmetic shift floors, i.e. truncates toward -inf
    assign w_q       = w_biased >>> DRP;
    assign w_inexact = |i_val[DRP-1:0];
  end

  // Saturate against the output range; the comparison sees the full width
  always_comb begin
    o_diff          = w_q[OW-1:0];
    o_flags         = '0;
    o_flags.inexact = w_inexact;
    if (w_q > C_MAX) begin
      o_diff           = C_MAX;
      o_flags.overflow = 1'b1;
    end else if (w_q < C_MIN) begin
      o_diff            = C_MIN;
      o_flags.underflow = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sub_fp.sv
`default_nettype none
// ============================================================================
//  Module      : sub_fp
//  Description : 3-stage pipelined signed fixed-point subtractor
//                diff = a - b, requantized and saturated to OUT_INT.OUT_FRAC,
//                valid/ready on both sides.
//                Macro SUB_FP_ROUND_EN: round half up in requantization.
//  Revision    : 1.0 - initial release
// ============================================================================
module sub_fp
  import fp_pkg::*;
#(
  parameter int INT_A    = 4,
  parameter int FRAC_A   = 5,
  parameter int INT_B    = 3,
  parameter int FRAC_B   = 5,
  parameter int OUT_INT  = 3,
  parameter int OUT_FRAC = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [INT_A+FRAC_A-1:0]     a,
  input  logic [INT_B+FRAC_B-1:0]     b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_INT+OUT_FRAC-1:0] diff,
  output logic                        overflow,
  output logic                        underflow,
  output logic                        inexact
);

  localparam int IMAX = fp_max(INT_A, INT_B);
  localparam int FMAX = fp_max(FRAC_A, FRAC_B);
  localparam int W    = IMAX + FMAX;
  localparam int OW   = OUT_INT + OUT_FRAC;

  logic          r_s1_valid;
  logic          r_s2_valid;
  logic          r_s3_valid;
  logic [W-1:0]  r_a_al;
  logic [W-1:0]  r_b_al;
  logic [W:0]    r_d;
  logic [OW-1:0] r_diff;
  fp_flags_t     r_flags;

  logic          w_s1_en;
  logic          w_s2_en;
  logic          w_s3_en;
  logic signed [W-1:0] w_a_sx;
  logic signed [W-1:0] w_b_sx;
  logic [W-1:0]  w_a_al;
  logic [W-1:0]  w_b_al;
  logic signed [W:0] w_d;
  logic [OW-1:0] w_rq_diff;
  fp_flags_t     w_rq_flags;

  // A stage may load when it is empty or its successor is taking its data
  assign w_s3_en  = !r_s3_valid | out_ready;
  assign w_s2_en  = !r_s2_valid | w_s3_en;
  assign w_s1_en  = !r_s1_valid | w_s2_en;
  assign in_ready = w_s1_en;

  // Align: sign-extend integer part, zero-pad fraction to FMAX
  assign w_a_sx = W'($signed(a));
  assign w_b_sx = W'($signed(b));
  assign w_a_al = w_a_sx <<< (FMAX - FRAC_A);
  assign w_b_al = w_b_sx <<< (FMAX - FRAC_B);

  // Guard bit keeps the difference exact
  assign w_d = $signed({r_a_al[W-1], r_a_al}) - $signed({r_b_al[W-1], r_b_al});

  fp_requant #(
    .IN_W     (W + 1),
    .IN_FRAC  (FMAX),
    .OUT_INT  (OUT_INT),
    .OUT_FRAC (OUT_FRAC)
  ) u_requant (
    .i_val   (r_d),
    .o_diff  (w_rq_diff),
    .o_flags (w_rq_flags)
  );

  // S1: register the aligned operand pair
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_a_al     <= '0;
      r_b_al     <= '0;
    end else if (w_s1_en) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_a_al <= w_a_al;
        r_b_al <= w_b_al;
      end
    end
  end

  // S2: register the exact W+1-bit difference
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s2_valid <= 1'b0;
      r_d        <= '0;
    end else if (w_s2_en) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_d <= w_d;
      end
    end
  end

  // S3: register the requantized result and flags; holds while stalled
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s3_valid <= 1'b0;
      r_diff     <= '0;
      r_flags    <= '0;
    end else if (w_s3_en) begin
      r_s3_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_diff  <= w_rq_diff;
        r_flags <= w_rq_flags;
      end
    end
  end

  assign out_valid = r_s3_valid;
  assign diff      = r_diff;
  assign overflow  = r_s3_valid & r_flags.overflow;
  assign underflow = r_s3_valid & r_flags.underflow;
  assign inexact   = r_s3_valid & r_flags.inexact;

endmodule
`default_nettype wire
